pdfd_tap_ctrl: RTL and testbench
================================

Name: pdfd_tap_ctrl

Overview:
Configuration and sequencing controller for the LaPDFD 4-lane decoder. It holds a shadow bank of 14 signed 8-bit DFE taps, written one tap at a time over a simple register interface. On commit it copies the shadow bank atomically into an active bank that drives the decoder taps. It then resets and flushes the decoder pipeline and masks decoder output until the pipeline holds only data decoded with the new taps.

Parameters:
NUM_TAPS, 14, number of DFE taps (active/shadow bank depth)
TAP_W, 8, tap width in bits, signed two's complement
ADDR_W, 4, tap address width; must satisfy 2^ADDR_W >= NUM_TAPS
RST_CYCLES, 2, cycles the decoder reset is held after a commit
FLUSH_CYCLES, 6, valid input beats discarded after the decoder reset is released

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
io_cfgWrEn  in  1  tap write strobe, one tap per cycle
io_cfgAddr  in  ADDR_W  tap index for the write
io_cfgData  in  TAP_W  signed tap value
io_cfgErr  out  1  one-cycle pulse: write to an address >= NUM_TAPS
io_commit  in  1  request to copy the shadow bank to the active bank
io_commitReady  out  1  high in IDLE and RUN only
io_busy  out  1  high in RESETDEC and FLUSH
io_inValid  in  1  upstream 4-sample beat is valid this cycle
io_taps_0..io_taps_13  out  TAP_W each  active taps to the decoder
io_decReset  out  1  synchronous reset to the decoder
io_pdfdData  in  8  decoder io_rxData
io_pdfdValid  in  1  decoder io_rxValid
io_rxData  out  8  gated decoded byte
io_rxValid  out  1  gated valid

Behaviour:
- Reset values: shadow and active banks all 0; state IDLE; io_decReset=1; io_rxValid=0; io_cfgErr=0; io_busy=0; io_commitReady=1.
- Shadow writes:
  - Accepted in every state.
  - If io_cfgWrEn is high and io_cfgAddr < NUM_TAPS, shadow[addr] <= io_cfgData on the next edge.
  - If addr >= NUM_TAPS, the write is dropped and io_cfgErr pulses high on the next cycle.
  - The active bank is never written directly.
- Commit: accepted only when io_commit && io_commitReady.
  - Sets active <= shadow.
  - A same-cycle valid write bypasses into the copied value, so the committed bank includes that write.
  - Next state is RESETDEC.
  - io_commit outside IDLE/RUN is ignored; it is not queued.
- States:
  - IDLE: io_decReset=1, io_rxValid=0. Leaves only on an accepted commit.
  - RESETDEC: io_decReset=1 for exactly RST_CYCLES cycles (counter), then go to FLUSH.
  - FLUSH: io_decReset=0. Counts cycles with io_inValid=1; after FLUSH_CYCLES such beats, go to RUN. Stalls indefinitely while io_inValid=0.
  - RUN: io_rxData = io_pdfdData and io_rxValid = io_pdfdValid (combinational pass-through). An accepted commit goes to RESETDEC, and io_rxValid drops to 0 from the next cycle.
- Output gating: io_rxValid=0 in every state except RUN. io_rxData is driven to 0 when not in RUN.
- Active taps change only on a commit edge. They are registered outputs and never glitch mid-flush.
- Reset mid-operation: any state returns to IDLE and both banks clear. The partial flush counter is discarded.
- Counters: RST counter width is clog2(RST_CYCLES+1); flush counter width is clog2(FLUSH_CYCLES+1). Both reload on entry to their state.
- Latency: commit accepted at edge N. io_decReset is high for cycles N+1..N+RST_CYCLES. RUN is entered FLUSH_CYCLES valid beats later; with io_inValid held high, RUN starts at cycle N+RST_CYCLES+FLUSH_CYCLES+1.

Decomposition:
- Package pdfd_pkg holds:
  - NUM_TAPS, TAP_W, ADDR_W;
  - typedef tap_t (signed TAP_W);
  - typedef tap_bank_t (tap_t array of NUM_TAPS);
  - state enum ctrl_state_e {IDLE, RESETDEC, FLUSH, RUN}.
- One natural sub-module: pdfd_tap_bank (shadow/active register pair with write port, bypass and commit copy). The FSM, counters and output gating stay in the top.

Test Plan:
1. Reset, then write taps -51,38,-3,23,-18,13,-10,8,-5,5,-3,3,0,0 to addresses 0..13 with no commit -> io_taps_* remain 0, state stays IDLE, io_decReset=1, io_rxValid=0.
2. Commit with io_inValid held high -> io_taps_* match the written values from the next cycle; io_decReset high for 2 cycles; io_rxValid stays 0 for 6 further cycles, then follows io_pdfdValid (drive 1 with data 0xA5 -> io_rxData=0xA5).
3. In FLUSH, toggle io_inValid 1,0,0,1,... -> only valid beats count; RUN is entered after exactly 6 high beats.
4. In RUN, write addr 0 = 7 and assert commit in the same cycle -> active tap0=7 on the next edge; io_rxValid=0 from the next cycle through the new flush.
5. Write addr 14 and addr 15 -> io_cfgErr pulses once per write; shadow unchanged; a subsequent commit shows no change to io_taps_*.
6. Assert reset during FLUSH -> next cycle state is IDLE, taps=0, io_decReset=1; commit during RESETDEC/FLUSH is ignored (io_commitReady=0, taps unchanged).

Source files
------------

// File: rtl/pdfd_pkg.sv
// Shared sizes and types for the LaPDFD tap controller.
package pdfd_pkg;
  localparam int NUM_TAPS     = 14;
  localparam int TAP_W        = 8;
  localparam int ADDR_W       = 4;
  localparam int RST_CYCLES   = 2;
  localparam int FLUSH_CYCLES = 6;

  typedef logic signed [TAP_W-1:0] tap_t;
  typedef tap_t [NUM_TAPS-1:0]     tap_bank_t;

  typedef enum logic [1:0] {IDLE, RESETDEC, FLUSH, RUN} ctrl_state_e;
endpackage

// File: rtl/pdfd_tap_ctrl_if.sv
// Tap configuration bus: per-tap writes plus the commit handshake.
interface pdfd_tap_ctrl_if;
  import pdfd_pkg::*;

  logic              io_cfgWrEn;
  logic [ADDR_W-1:0] io_cfgAddr;
  tap_t              io_cfgData;
  logic              io_cfgErr;
  logic              io_commit;
  logic              io_commitReady;

  modport master (output io_cfgWrEn, io_cfgAddr, io_cfgData, io_commit,
                  input  io_cfgErr, io_commitReady);
  modport slave  (input  io_cfgWrEn, io_cfgAddr, io_cfgData, io_commit,
                  output io_cfgErr, io_commitReady);
endinterface

// File: rtl/pdfd_tap_bank.sv
// Shadow/active tap register pair; a commit copies shadow (with any
// same-cycle write folded in) into the active bank in one edge.
module pdfd_tap_bank
  import pdfd_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  tap_t              i_wr_data,
  input  logic              i_commit,
  output tap_bank_t         o_active,
  output logic              o_err
);
  tap_bank_t r_shadow, r_active;
  tap_bank_t w_shadow_nxt;
  logic      w_wr_ok;
  logic      r_err;

  always_comb begin
    w_wr_ok      = i_wr_en && (i_wr_addr < ADDR_W'(NUM_TAPS));
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < NUM_TAPS; i++)
      if (w_wr_ok && (i_wr_addr == ADDR_W'(i))) w_shadow_nxt[i] = i_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_err    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_err    <= i_wr_en && !w_wr_ok;
      if (i_commit) r_active <= w_shadow_nxt;
    end
  end

  assign o_active = r_active;
  assign o_err    = r_err;
endmodule

// File: rtl/pdfd_tap_ctrl.sv
// LaPDFD tap controller: commit sequencing, decoder reset/flush and
// output gating so only data decoded with the new taps is passed on.
module pdfd_tap_ctrl
  import pdfd_pkg::*;
#(
  parameter int RST_CYCLES_P   = RST_CYCLES,
  parameter int FLUSH_CYCLES_P = FLUSH_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  pdfd_tap_ctrl_if.slave  cfg,
  input  logic            io_inValid,
  output logic            io_busy,
  output tap_t            io_taps_0,  io_taps_1,  io_taps_2,  io_taps_3,
  output tap_t            io_taps_4,  io_taps_5,  io_taps_6,  io_taps_7,
  output tap_t            io_taps_8,  io_taps_9,  io_taps_10, io_taps_11,
  output tap_t            io_taps_12, io_taps_13,
  output logic            io_decReset,
  input  logic [7:0]      io_pdfdData,
  input  logic            io_pdfdValid,
  output logic [7:0]      io_rxData,
  output logic            io_rxValid
);
  localparam int RW = $clog2(RST_CYCLES_P + 1);
  localparam int FW = $clog2(FLUSH_CYCLES_P + 1);

  ctrl_state_e r_state, w_state_nxt;
  logic [RW-1:0] r_rst_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          w_ready, w_commit_acc;
  tap_bank_t     w_active;

  pdfd_tap_bank u_bank (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (cfg.io_cfgWrEn),
    .i_wr_addr (cfg.io_cfgAddr),
    .i_wr_data (cfg.io_cfgData),
    .i_commit  (w_commit_acc),
    .o_active  (w_active),
    .o_err     (cfg.io_cfgErr)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = (r_state == IDLE) || (r_state == RUN);
    w_commit_acc = cfg.io_commit && w_ready;
    unique case (r_state)
      IDLE, RUN: if (w_commit_acc) w_state_nxt = RESETDEC;
      RESETDEC:  if (r_rst_cnt == RW'(1)) w_state_nxt = FLUSH;
      FLUSH:     if (io_inValid && (r_flush_cnt == FW'(1))) w_state_nxt = RUN;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Counters reload on entry to their state and count down to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_commit_acc)             r_rst_cnt <= RW'(RST_CYCLES_P);
      else if (r_state == RESETDEC) r_rst_cnt <= r_rst_cnt - RW'(1);
      if (r_state == RESETDEC && w_state_nxt == FLUSH)
        r_flush_cnt <= FW'(FLUSH_CYCLES_P);
      else if (r_state == FLUSH && io_inValid)
        r_flush_cnt <= r_flush_cnt - FW'(1);
    end
  end

  assign cfg.io_commitReady = w_ready;
  assign io_busy     = (r_state == RESETDEC) || (r_state == FLUSH);
  assign io_decReset = (r_state == IDLE) || (r_state == RESETDEC);
  assign io_rxValid  = (r_state == RUN) && io_pdfdValid;
  assign io_rxData   = (r_state == RUN) ? io_pdfdData : 8'h00;

  assign io_taps_0  = w_active[0];  assign io_taps_1  = w_active[1];
  assign io_taps_2  = w_active[2];  assign io_taps_3  = w_active[3];
  assign io_taps_4  = w_active[4];  assign io_taps_5  = w_active[5];
  assign io_taps_6  = w_active[6];  assign io_taps_7  = w_active[7];
  assign io_taps_8  = w_active[8];  assign io_taps_9  = w_active[9];
  assign io_taps_10 = w_active[10]; assign io_taps_11 = w_active[11];
  assign io_taps_12 = w_active[12]; assign io_taps_13 = w_active[13];
endmodule

// File: tb/tb_pdfd_tap_ctrl.sv
// Directed bench for pdfd_tap_ctrl: tap writes, commit sequencing, flush gating.
module tb_pdfd_tap_ctrl;
  import pdfd_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic io_inValid, io_busy, io_decReset, io_pdfdValid, io_rxValid;
  logic [7:0] io_pdfdData, io_rxData;
  tap_t t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13;
  logic [7:0] taps [14];
  logic [7:0] exp_taps [14];
  int vectors = 0;
  int miscompares = 0;

  pdfd_tap_ctrl_if cfg ();

  pdfd_tap_ctrl dut (
    .clock(clock), .reset(reset), .cfg(cfg), .io_inValid(io_inValid),
    .io_busy(io_busy),
    .io_taps_0(t0), .io_taps_1(t1), .io_taps_2(t2), .io_taps_3(t3),
    .io_taps_4(t4), .io_taps_5(t5), .io_taps_6(t6), .io_taps_7(t7),
    .io_taps_8(t8), .io_taps_9(t9), .io_taps_10(t10), .io_taps_11(t11),
    .io_taps_12(t12), .io_taps_13(t13),
    .io_decReset(io_decReset), .io_pdfdData(io_pdfdData),
    .io_pdfdValid(io_pdfdValid), .io_rxData(io_rxData), .io_rxValid(io_rxValid)
  );

  always #5 clock = ~clock;

  always_comb begin
    taps[0] = t0;  taps[1] = t1;  taps[2] = t2;   taps[3] = t3;
    taps[4] = t4;  taps[5] = t5;  taps[6] = t6;   taps[7] = t7;
    taps[8] = t8;  taps[9] = t9;  taps[10] = t10; taps[11] = t11;
    taps[12] = t12; taps[13] = t13;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_taps(input string tag);
    for (int i = 0; i < 14; i++)
      check($sformatf("%s_tap%0d", tag, i), {24'h0, taps[i]}, {24'h0, exp_taps[i]});
  endtask

  task automatic write(input int addr, input int val);
    cfg.io_cfgWrEn = 1'b1;
    cfg.io_cfgAddr = 4'(addr);
    cfg.io_cfgData = 8'(val);
  endtask

  int vals [14] = '{-51, 38, -3, 23, -18, 13, -10, 8, -5, 5, -3, 3, 0, 0};
  int pat  [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1};

  initial begin
    reset = 1'b1; io_inValid = 1'b0; io_pdfdValid = 1'b1; io_pdfdData = 8'hA5;
    cfg.io_cfgWrEn = 1'b0; cfg.io_cfgAddr = '0; cfg.io_cfgData = '0; cfg.io_commit = 1'b0;
    for (int i = 0; i < 14; i++) exp_taps[i] = 8'h00;
    tick(); tick();
    check("rst_decReset", io_decReset, 1);
    check("rst_ready", cfg.io_commitReady, 1);
    check("rst_busy", io_busy, 0);
    check("rst_rxValid", io_rxValid, 0);
    check("rst_rxData", io_rxData, 0);
    check("rst_cfgErr", cfg.io_cfgErr, 0);
    check_taps("rst");
    reset = 1'b0;

    // 1: shadow writes without commit leave active bank at zero
    for (int i = 0; i < 14; i++) begin write(i, vals[i]); tick(); end
    cfg.io_cfgWrEn = 1'b0;
    tick();
    check_taps("t1");
    check("t1_decReset", io_decReset, 1);
    check("t1_ready", cfg.io_commitReady, 1);
    check("t1_rxValid", io_rxValid, 0);
    check("t1_cfgErr", cfg.io_cfgErr, 0);

    // 2: commit with inValid held high
    io_inValid = 1'b1; cfg.io_commit = 1'b1;
    tick();
    cfg.io_commit = 1'b0;
    for (int i = 0; i < 14; i++) exp_taps[i] = 8'(vals[i]);
    check_taps("t2");
    check("t2_decReset_c1", io_decReset, 1);
    check("t2_busy", io_busy, 1);
    check("t2_ready", cfg.io_commitReady, 0);
    tick();
    check("t2_decReset_c2", io_decReset, 1);
    tick();
    check("t2_decReset_c3", io_decReset, 0);
    check("t2_rxValid_f0", io_rxValid, 0);
    for (int k = 1; k < 6; k++) begin
      tick();
      check($sformatf("t2_rxValid_f%0d", k), io_rxValid, 0);
    end
    tick();
    check("t2_run_rxValid", io_rxValid, 1);
    check("t2_run_rxData", io_rxData, 8'hA5);
    check("t2_run_busy", io_busy, 0);
    check("t2_run_ready", cfg.io_commitReady, 1);

    // 3: flush only counts valid beats
    cfg.io_commit = 1'b1;
    tick();
    cfg.io_commit = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t3_flush_busy%0d", k), io_busy, 1);
      check($sformatf("t3_flush_rxValid%0d", k), io_rxValid, 0);
      io_inValid = pat[k][0];
      tick();
    end
    check("t3_run_busy", io_busy, 0);
    check("t3_run_rxValid", io_rxValid, 1);
    check_taps("t3");

    // 4: same-cycle write bypasses into the commit
    io_inValid = 1'b1;
    write(0, 7); cfg.io_commit = 1'b1;
    tick();
    cfg.io_cfgWrEn = 1'b0; cfg.io_commit = 1'b0;
    exp_taps[0] = 8'd7;
    check_taps("t4");
    check("t4_rxValid_c1", io_rxValid, 0);
    for (int k = 2; k < 9; k++) begin
      tick();
      check($sformatf("t4_rxValid_c%0d", k), io_rxValid, 0);
    end
    tick();
    check("t4_run_rxValid", io_rxValid, 1);

    // 5: out-of-range writes are dropped and flagged
    write(14, 55);
    tick();
    check("t5_err14", cfg.io_cfgErr, 1);
    write(15, -1);
    tick();
    check("t5_err15", cfg.io_cfgErr, 1);
    cfg.io_cfgWrEn = 1'b0;
    tick();
    check("t5_err_clr", cfg.io_cfgErr, 0);
    cfg.io_commit = 1'b1;
    tick();
    check_taps("t5");

    // 6: commits outside IDLE/RUN are ignored; reset mid-flush clears all
    check("t6_ready_rd", cfg.io_commitReady, 0);
    write(1, 100);
    tick();
    cfg.io_cfgWrEn = 1'b0;
    check_taps("t6_rd");
    io_inValid = 1'b0;
    tick();
    check("t6_flush_busy", io_busy, 1);
    check("t6_flush_decReset", io_decReset, 0);
    check("t6_flush_ready", cfg.io_commitReady, 0);
    tick();
    cfg.io_commit = 1'b0;
    check("t6_stall_busy", io_busy, 1);
    check_taps("t6_fl");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) exp_taps[i] = 8'h00;
    check_taps("t6_rst");
    check("t6_rst_decReset", io_decReset, 1);
    check("t6_rst_ready", cfg.io_commitReady, 1);
    check("t6_rst_busy", io_busy, 0);
    cfg.io_commit = 1'b1;
    tick();
    cfg.io_commit = 1'b0;
    check_taps("t6_shadow_clr");
    check("t6_recommit_busy", io_busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
